i2c_reg_access: RTL and testbench
=================================

# i2c_reg_access

Register-level transaction sequencer that sits directly upstream of the I2C byte master. It accepts one command at a time: device address, register pointer, and 1–4 data bytes to write or read. It then drives the master's start, send and receive handshake to run the full bus sequence: START, address+W, register, then either data bytes or repeated START, address+R and data bytes, ending in STOP. It returns read data and a completion status to the host logic, such as a sensor poller or a CPU bridge.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 20'd1_000_000: maximum number of clk cycles without master progress before the command is aborted.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when the block can accept a command.
- cmd_read  in  1  1 = register read, 0 = register write.
- cmd_dev  in  7  7-bit device address.
- cmd_reg  in  8  register pointer.
- cmd_len  in  3  byte count, 1–4; values 0 and 5–7 are treated as 1.
- cmd_wdata  in  32  write bytes; byte0 = [7:0] is sent first.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_valid; 1 = NACK or timeout.
- rsp_rdata  out  32  read bytes; byte0 lands in [7:0]; unread bytes are 0.
- m_start  out  1  master start / repeated-start request.
- m_ready  in  1  master idle.
- m_send  out  1  continue-write request.
- m_datasend  out  8  byte presented to the master; bit0 is the R/W flag during address bytes.
- m_sended  in  1  pulse when the master is in the ACK window after a transmitted byte.
- m_receive  out  1  continue-read request.
- m_datareceive  in  8  last received byte.
- m_received  in  1  pulse when a received byte is valid.

## Operation
- Command capture: a command is accepted on the cycle cmd_valid && cmd_ready. All cmd_* fields are latched. The byte counter is set to len (clamped) and the abort counter is cleared.
- States: IDLE, START, ADDR_W, REG, WDATA, RESTART, ADDR_R, RDATA, STOPWAIT, RESP.
- IDLE:
  - cmd_ready = m_ready.
  - On accept: m_datasend = {dev,1'b0}, m_start = 1 for one cycle, go to START.
- START: wait for m_ready to fall, then go to ADDR_W.
- ADDR_W: on m_sended, m_datasend = reg and m_send = 1; go to REG.
- REG: on m_sended:
  - Write command: m_datasend = next write byte, m_send = 1, go to WDATA.
  - Read command: m_send = 0, m_datasend = {dev,1'b1}, m_start = 1 for one cycle, go to RESTART.
- WDATA: on each m_sended, decrement the counter.
  - If bytes remain: present the next byte and keep m_send = 1.
  - Otherwise: m_send = 0 and go to STOPWAIT.
- RESTART: on m_sended (the address+R byte's ACK window), m_receive = 1 and go to RDATA.
- RDATA: on each m_received:
  - Store m_datareceive into rsp_rdata at byte index len−counter, then decrement the counter.
  - m_receive = (counter after decrement ≠ 0), so the master NACKs the last byte.
  - When the counter reaches 0, go to STOPWAIT.
- STOPWAIT: wait for m_ready = 1, then go to RESP.
- RESP: rsp_valid = 1 for one cycle, then go to IDLE.
- m_send and m_receive are registered levels. They are held stable from the m_sended/m_received pulse until the next such pulse, or until STOPWAIT.
- m_datasend is stable at all times except the cycle after a handshake pulse.
- Error, NACK: m_ready rising in any state other than STOPWAIT or IDLE means the master saw NACK and stopped. The block sets rsp_err = 1 and goes to RESP.
- Error, timeout: the abort counter is cleared on every m_sended, m_received or state change, and increments otherwise. At TIMEOUT_CYCLES−1 the block drops m_send, m_receive and m_start, sets rsp_err = 1 and goes to STOPWAIT.
- The master does not return to idle on a timeout unless it stops on its own. The integrator resets both blocks.

## Timing
- Reset values:
  - cmd_ready 0 (it follows m_ready after the first cycle).
  - rsp_valid 0, rsp_err 0, rsp_rdata 0.
  - m_start 0, m_send 0, m_receive 0, m_datasend 0.
  - State IDLE, counters 0.
- Reset mid-transaction returns to IDLE within one cycle with all outputs at their reset values. No response is issued.
- m_start is exactly one clk wide. It is issued at most once in START and once in RESTART.
- Every output reacts to m_sended/m_received one cycle after the pulse, which is well inside the master's half-bit wait window.
- rsp_valid occurs one cycle after m_ready is seen high in STOPWAIT.
- cmd_ready is 0 from accept through the RESP cycle.
- rsp_rdata is held until the next accept, where it is cleared to 0.

## Structure
- Package i2c_pkg holds:
  - the state enum;
  - the RW_WRITE/RW_READ constants;
  - the MAX_LEN = 4 constant;
  - the byte-lane select function, shared with the master's testbench model.
- A sub-module i2c_abort_timer holds the abort counter: clear/enable in, expire out, with parameter TIMEOUT_CYCLES.
- The FSM remains in i2c_reg_access.

## Test plan
- Write, dev 0x50, reg 0x10, len 2, wdata 0x0000BEEF: bytes on the bus are A0 10 EF BE, then STOP. Expect rsp_valid with rsp_err = 0.
- Read, dev 0x68, reg 0x75, len 1, slave returns 0x71: bus shows A0 is not used; bytes are D0 75, Sr, D1, then 71 with NACK and STOP. Expect rsp_rdata = 0x00000071, err 0.
- Read, len 4, slave returns 11 22 33 44: the first three bytes are ACKed, the last is NACKed. Expect rsp_rdata = 0x44332211.
- No slave at dev 0x2A: the address byte is NACKed and the master returns to idle. Expect rsp_valid with rsp_err = 1 and no data bytes driven.
- A slave holding SCL so that there is no m_sended for TIMEOUT_CYCLES (set to 100 in the bench): expect rsp_err = 1 and m_send = m_receive = 0. Also assert reset mid-read: expect IDLE, no rsp_valid, and outputs at their reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C register-access sequencer and its
// master-side test models.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR_W,
        ST_REG,
        ST_WDATA,
        ST_RESTART,
        ST_ADDR_R,
        ST_RDATA,
        ST_STOPWAIT,
        ST_RESP
    } state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;
    localparam int   MAX_LEN  = 4;

    // Byte lane of a little-endian 32-bit word: lane 0 is [7:0].
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            2'd2:    return word[23:16];
            default: return word[31:24];
        endcase
    endfunction

    // Out-of-range lengths collapse to a single byte.
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        if (len == 3'd0 || len > 3'(MAX_LEN)) begin
            return 3'd1;
        end
        return len;
    endfunction

endpackage

// File: rtl/i2c_abort_timer.sv
// Abort watchdog: counts enabled cycles without progress and flags expiry
// on the last allowed cycle.
module i2c_abort_timer #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    logic [19:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 20'd1;
        end
    end

    assign o_expire = i_enable && (r_count == TIMEOUT_CYCLES - 20'd1);

endmodule

// File: rtl/i2c_reg_access.sv
// Register-level I2C transaction sequencer: turns one host command into the
// byte master's start/send/receive handshake and reports data plus status.
module i2c_reg_access
    import i2c_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [6:0]  cmd_dev,
    input  logic [7:0]  cmd_reg,
    input  logic [2:0]  cmd_len,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        m_start,
    input  logic        m_ready,
    output logic        m_send,
    output logic [7:0]  m_datasend,
    input  logic        m_sended,
    output logic        m_receive,
    input  logic [7:0]  m_datareceive,
    input  logic        m_received
);

    state_t      r_state;
    logic        r_read;
    logic [6:0]  r_dev;
    logic [7:0]  r_reg;
    logic [2:0]  r_len;
    logic [2:0]  r_cnt;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_m_start;
    logic        r_m_send;
    logic        r_m_receive;
    logic [7:0]  r_m_datasend;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic        r_cmd_ready;
    logic        r_m_ready_d;

    state_t      w_state_next;
    logic        w_read_next;
    logic [6:0]  w_dev_next;
    logic [7:0]  w_reg_next;
    logic [2:0]  w_len_next;
    logic [2:0]  w_cnt_next;
    logic [31:0] w_wdata_next;
    logic [31:0] w_rdata_next;
    logic        w_m_start_next;
    logic        w_m_send_next;
    logic        w_m_receive_next;
    logic [7:0]  w_m_datasend_next;
    logic        w_rsp_valid_next;
    logic        w_rsp_err_next;
    logic        w_cmd_ready_next;

    logic        w_active;
    logic        w_nack;
    logic        w_expire;
    logic        w_timer_clear;
    logic [1:0]  w_rx_idx;
    logic [1:0]  w_tx_idx;
    logic [3:0]  w_lane_sel;

    // Byte lanes: receive lane uses the pre-decrement count, transmit lane the post-decrement one.
    assign w_rx_idx = 2'(r_len - r_cnt);
    assign w_tx_idx = 2'(r_len - r_cnt + 3'd1);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_lane
            assign w_lane_sel[gi] = (w_rx_idx == 2'(gi));
        end
    endgenerate

    assign w_active = (r_state == ST_START)   || (r_state == ST_ADDR_W) ||
                      (r_state == ST_REG)     || (r_state == ST_WDATA)  ||
                      (r_state == ST_RESTART) || (r_state == ST_ADDR_R) ||
                      (r_state == ST_RDATA);

    // The master only drops back to idle mid-transfer after a NACK.
    assign w_nack        = w_active && m_ready && !r_m_ready_d;
    assign w_timer_clear = m_sended || m_received || (w_state_next != r_state);

    i2c_abort_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_abort_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_timer_clear),
        .i_enable (w_active),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_next      = r_state;
        w_read_next       = r_read;
        w_dev_next        = r_dev;
        w_reg_next        = r_reg;
        w_len_next        = r_len;
        w_cnt_next        = r_cnt;
        w_wdata_next      = r_wdata;
        w_rdata_next      = r_rdata;
        w_m_start_next    = 1'b0;
        w_m_send_next     = r_m_send;
        w_m_receive_next  = r_m_receive;
        w_m_datasend_next = r_m_datasend;
        w_rsp_valid_next  = 1'b0;
        w_rsp_err_next    = r_rsp_err;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_read_next       = cmd_read;
                    w_dev_next        = cmd_dev;
                    w_reg_next        = cmd_reg;
                    w_len_next        = clamp_len(cmd_len);
                    w_cnt_next        = clamp_len(cmd_len);
                    w_wdata_next      = cmd_wdata;
                    w_rdata_next      = '0;
                    w_rsp_err_next    = 1'b0;
                    w_m_datasend_next = {cmd_dev, RW_WRITE};
                    w_m_start_next    = 1'b1;
                    w_state_next      = ST_START;
                end
            end
            ST_START: begin
                if (!m_ready) begin
                    w_state_next = ST_ADDR_W;
                end
            end
            ST_ADDR_W: begin
                if (m_sended) begin
                    w_m_datasend_next = r_reg;
                    w_m_send_next     = 1'b1;
                    w_state_next      = ST_REG;
                end
            end
            ST_REG: begin
                if (m_sended) begin
                    if (r_read == RW_READ) begin
                        w_m_send_next     = 1'b0;
                        w_m_datasend_next = {r_dev, RW_READ};
                        w_m_start_next    = 1'b1;
                        w_state_next      = ST_RESTART;
                    end else begin
                        w_m_datasend_next = byte_lane(r_wdata, 2'd0);
                        w_m_send_next     = 1'b1;
                        w_state_next      = ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                if (m_sended) begin
                    w_cnt_next = r_cnt - 3'd1;
                    if (w_cnt_next != 3'd0) begin
                        w_m_datasend_next = byte_lane(r_wdata, w_tx_idx);
                    end else begin
                        w_m_send_next = 1'b0;
                        w_state_next  = ST_STOPWAIT;
                    end
                end
            end
            ST_RESTART, ST_ADDR_R: begin
                if (m_sended) begin
                    w_m_receive_next = 1'b1;
                    w_state_next     = ST_RDATA;
                end else if (r_state == ST_RESTART) begin
                    w_state_next = ST_ADDR_R;
                end
            end
            ST_RDATA: begin
                if (m_received) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (w_lane_sel[i]) begin
                            w_rdata_next[8*i +: 8] = m_datareceive;
                        end
                    end
                    w_cnt_next       = r_cnt - 3'd1;
                    w_m_receive_next = (w_cnt_next != 3'd0);
                    if (w_cnt_next == 3'd0) begin
                        w_state_next = ST_STOPWAIT;
                    end
                end
            end
            ST_STOPWAIT: begin
                if (m_ready) begin
                    w_rsp_valid_next = 1'b1;
                    w_state_next     = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_nack) begin
            w_m_start_next   = 1'b0;
            w_m_send_next    = 1'b0;
            w_m_receive_next = 1'b0;
            w_rsp_err_next   = 1'b1;
            w_rsp_valid_next = 1'b1;
            w_state_next     = ST_RESP;
        end else if (w_expire) begin
            // Wait for the master to stop on its own before responding.
            w_m_start_next   = 1'b0;
            w_m_send_next    = 1'b0;
            w_m_receive_next = 1'b0;
            w_rsp_err_next   = 1'b1;
            w_state_next     = ST_STOPWAIT;
        end

        w_cmd_ready_next = (w_state_next == ST_IDLE) && m_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_read       <= RW_WRITE;
            r_dev        <= '0;
            r_reg        <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_m_start    <= 1'b0;
            r_m_send     <= 1'b0;
            r_m_receive  <= 1'b0;
            r_m_datasend <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_m_ready_d  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_read       <= w_read_next;
            r_dev        <= w_dev_next;
            r_reg        <= w_reg_next;
            r_len        <= w_len_next;
            r_cnt        <= w_cnt_next;
            r_wdata      <= w_wdata_next;
            r_rdata      <= w_rdata_next;
            r_m_start    <= w_m_start_next;
            r_m_send     <= w_m_send_next;
            r_m_receive  <= w_m_receive_next;
            r_m_datasend <= w_m_datasend_next;
            r_rsp_valid  <= w_rsp_valid_next;
            r_rsp_err    <= w_rsp_err_next;
            r_cmd_ready  <= w_cmd_ready_next;
            r_m_ready_d  <= m_ready;
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_rdata  = r_rdata;
    assign m_start    = r_m_start;
    assign m_send     = r_m_send;
    assign m_receive  = r_m_receive;
    assign m_datasend = r_m_datasend;

endmodule

// File: tb/tb_i2c_reg_access.sv
// Directed bench for i2c_reg_access with a behavioural byte-master model that
// logs every byte, repeated start and read ACK/NACK seen on the bus.
module tb_i2c_reg_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [6:0]  cmd_dev;
    logic [7:0]  cmd_reg;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        m_start;
    logic        m_ready;
    logic        m_send;
    logic [7:0]  m_datasend;
    logic        m_sended;
    logic        m_receive;
    logic [7:0]  m_datareceive;
    logic        m_received;

    int          total = 0;
    int          bad   = 0;
    int          log_q[$];
    int          exp_q[$];
    logic        got_err;
    logic [31:0] got_rdata;
    int          pulses;

    always #5 clk = ~clk;

    i2c_reg_access #(
        .TIMEOUT_CYCLES(20'd100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_read      (cmd_read),
        .cmd_dev       (cmd_dev),
        .cmd_reg       (cmd_reg),
        .cmd_len       (cmd_len),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_err       (rsp_err),
        .rsp_rdata     (rsp_rdata),
        .m_start       (m_start),
        .m_ready       (m_ready),
        .m_send        (m_send),
        .m_datasend    (m_datasend),
        .m_sended      (m_sended),
        .m_receive     (m_receive),
        .m_datareceive (m_datareceive),
        .m_received    (m_received)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [2:0] len, input logic [31:0] wd);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_read  = rd;
        cmd_dev   = dev;
        cmd_reg   = rg;
        cmd_len   = len;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    endtask

    // Byte-master model. nack_at/stall_at index transmitted bytes; rst_after counts received bytes.
    task automatic run_master(input int nack_at, input int stall_at, input int rst_after,
                              input logic [31:0] rx);
        int   n = 0;
        int   tx = 0;
        int   rxn = 0;
        bit   done = 0;
        logic ack;
        logic [7:0] b;
        log_q.delete();
        while (!m_start && n < 20) begin
            tick();
            n++;
        end
        chk("m_start_seen", 32'(m_start), 32'd1);
        m_ready = 1'b0;
        log_q.push_back(int'(m_datasend));
        tick();
        chk("m_start_width", 32'(m_start), 32'd0);
        while (!done) begin
            if (tx == stall_at) return;
            repeat (3) tick();
            m_sended = 1'b1;
            tick();
            m_sended = 1'b0;
            if (tx == nack_at) begin
                repeat (2) tick();
                m_ready = 1'b1;
                return;
            end
            tx++;
            if (m_start) begin
                log_q.push_back(32'h100);
                log_q.push_back(int'(m_datasend));
                tick();
                chk("m_rstart_width", 32'(m_start), 32'd0);
            end else if (m_receive) begin
                while (1) begin
                    repeat (3) tick();
                    b = rx[8*rxn +: 8];
                    m_datareceive = b;
                    m_received = 1'b1;
                    tick();
                    m_received = 1'b0;
                    ack = m_receive;
                    log_q.push_back(ack ? (32'h200 | int'(b)) : (32'h400 | int'(b)));
                    rxn++;
                    if (rxn == rst_after) begin
                        reset = 1'b0;
                        tick();
                        return;
                    end
                    if (!ack || rxn >= 4) break;
                end
                done = 1;
            end else if (m_send) begin
                log_q.push_back(int'(m_datasend));
            end else begin
                done = 1;
            end
            if (tx > 8) done = 1;
        end
        repeat (3) tick();
        m_ready = 1'b1;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        got_err   = rsp_err;
        got_rdata = rsp_rdata;
        tick();
        chk("rsp_valid_width", 32'(rsp_valid), 32'd0);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_m_start"}, 32'(m_start), 32'd0);
        chk({tag, "_m_send"}, 32'(m_send), 32'd0);
        chk({tag, "_m_receive"}, 32'(m_receive), 32'd0);
        chk({tag, "_m_datasend"}, 32'(m_datasend), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_read      = 1'b0;
        cmd_dev       = '0;
        cmd_reg       = '0;
        cmd_len       = '0;
        cmd_wdata     = '0;
        m_ready       = 1'b1;
        m_sended      = 1'b0;
        m_received    = 1'b0;
        m_datareceive = '0;
        repeat (3) tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        repeat (2) tick();
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);

        // Write two bytes.
        issue(1'b0, 7'h50, 8'h10, 3'd2, 32'h0000BEEF);
        run_master(-1, -1, -1, 32'h0);
        wait_rsp();
        $display("txn wr dev=50 reg=10 len=2 err=%0d", got_err);
        chk("wr2_err", 32'(got_err), 32'd0);
        exp_q = '{32'hA0, 32'h10, 32'hEF, 32'hBE};
        check_log("wr2_bus");

        // Read one byte.
        issue(1'b1, 7'h68, 8'h75, 3'd1, 32'h0);
        run_master(-1, -1, -1, 32'h00000071);
        wait_rsp();
        $display("txn rd dev=68 reg=75 len=1 err=%0d rdata=%h", got_err, got_rdata);
        chk("rd1_err", 32'(got_err), 32'd0);
        chk("rd1_rdata", got_rdata, 32'h00000071);
        exp_q = '{32'hD0, 32'h75, 32'h100, 32'hD1, 32'h471};
        check_log("rd1_bus");

        // Read four bytes: last one NACKed.
        issue(1'b1, 7'h68, 8'h75, 3'd4, 32'h0);
        run_master(-1, -1, -1, 32'h44332211);
        wait_rsp();
        $display("txn rd dev=68 reg=75 len=4 err=%0d rdata=%h", got_err, got_rdata);
        chk("rd4_err", 32'(got_err), 32'd0);
        chk("rd4_rdata", got_rdata, 32'h44332211);
        exp_q = '{32'hD0, 32'h75, 32'h100, 32'hD1, 32'h211, 32'h222, 32'h233, 32'h444};
        check_log("rd4_bus");

        // Length 0 is treated as one byte; read data is cleared on accept.
        issue(1'b0, 7'h3C, 8'h01, 3'd0, 32'hFFFFFF5A);
        run_master(-1, -1, -1, 32'h0);
        wait_rsp();
        $display("txn wr dev=3C reg=01 len=0 err=%0d rdata=%h", got_err, got_rdata);
        chk("wr0_err", 32'(got_err), 32'd0);
        chk("wr0_rdata_clr", got_rdata, 32'h0);
        exp_q = '{32'h78, 32'h01, 32'h5A};
        check_log("wr0_bus");

        // Absent device: address NACKed.
        issue(1'b0, 7'h2A, 8'h10, 3'd2, 32'h0000BEEF);
        run_master(0, -1, -1, 32'h0);
        wait_rsp();
        $display("txn wr dev=2A nack err=%0d", got_err);
        chk("nack_err", 32'(got_err), 32'd1);
        chk("nack_m_send", 32'(m_send), 32'd0);
        exp_q = '{32'h54};
        check_log("nack_bus");

        // Slave stalls the register byte: timeout.
        issue(1'b0, 7'h50, 8'h10, 3'd1, 32'h000000AA);
        run_master(-1, 1, -1, 32'h0);
        repeat (90) tick();
        chk("stall_early_m_send", 32'(m_send), 32'd1);
        repeat (20) tick();
        chk("tmo_m_send", 32'(m_send), 32'd0);
        chk("tmo_m_receive", 32'(m_receive), 32'd0);
        chk("tmo_no_rsp_yet", 32'(rsp_valid), 32'd0);
        m_ready = 1'b1;
        wait_rsp();
        $display("txn wr dev=50 timeout err=%0d", got_err);
        chk("tmo_err", 32'(got_err), 32'd1);

        // Reset in the middle of a four-byte read.
        issue(1'b1, 7'h68, 8'h75, 3'd4, 32'h0);
        run_master(-1, -1, 2, 32'h44332211);
        check_reset_outputs("midrst");
        reset   = 1'b1;
        m_ready = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) pulses++;
        end
        $display("txn rd dev=68 reset-abort rsp_pulses=%0d", pulses);
        chk("midrst_no_rsp", 32'(pulses), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
